// File: rtl/video_scanout.sv
// video_scanout: parametrised framebuffer scan-out with VGA timing,
// line FIFO, frame-coherent base/zoom/enable and underflow reporting.
module video_scanout #(
  parameter int CORDW      = 11,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              enable,
  input  logic              zoom,
  input  logic [ADDR_W-1:0] base_adr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [15:0]       rgb,
  output logic              frame_start,
  output logic              underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CORDW-1:0] H_LAST =
    CORDW'(H_RES + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CORDW-1:0] V_LAST =
    CORDW'(V_RES + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CORDW-1:0] H_VIS = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_VIS = CORDW'(V_RES);
  localparam logic [CORDW-1:0] V_PRE = CORDW'(V_RES - 1);
  localparam logic [CORDW-1:0] HS_ON = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_OFF =
    CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_ON = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_OFF =
    CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] W_NAT = CORDW'(H_RES / 2);
  localparam logic [CORDW-1:0] W_ZOOM = CORDW'(H_RES / 4);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  logic [CORDW-1:0]  hcnt;
  logic [CORDW-1:0]  vcnt;
  logic              sh_en;
  logic              sh_zoom;
  logic [ADDR_W-1:0] line_adr;
  logic [ADDR_W-1:0] nxt_line;
  logic [CORDW-1:0]  remaining;
  logic [CORDW-1:0]  words;
  logic              busy;
  logic              stale;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [31:0]       head;
  logic [31:0]       cur_word;
  logic              cur_valid;

  logic tick_frame;
  logic tick_arm;
  logic kill;
  logic want;
  logic push;
  logic pop;
  logic pop_due;
  logic in_de;
  logic half;
  logic fifo_empty;

  // event decode, request generation and next line address
  always_comb begin
    tick_frame = ce && (hcnt == '0) && (vcnt == V_LAST);
    tick_arm   = ce && (hcnt == H_VIS) &&
                 ((vcnt == V_LAST) || (vcnt < V_PRE));
    kill       = tick_frame || tick_arm;
    words      = sh_zoom ? W_ZOOM : W_NAT;
    fifo_empty = (count == '0);
    want       = sh_en && (remaining != '0) &&
                 (count < FULL) && !stale;
    mem_req    = busy || want;
    push       = mem_req && mem_ack && !stale && !kill;
    in_de      = (hcnt < H_VIS) && (vcnt < V_VIS);
    pop_due    = ce && in_de && sh_en &&
                 (sh_zoom ? (hcnt[1:0] == 2'b00) : !hcnt[0]);
    pop        = pop_due && !fifo_empty && !kill;
    half       = sh_zoom ? hcnt[1] : hcnt[0];
    head       = fifo_mem[rd_ptr];
    nxt_line   = line_adr + ADDR_W'(words);
    if (tick_frame) begin
      nxt_line = base_adr;
    end else if (vcnt == V_LAST) begin
      nxt_line = line_adr;
    end else if (sh_zoom && !vcnt[0]) begin
      nxt_line = line_adr;
    end
  end

  // raster counters advance on pixel-clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // shadow controls only change at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en   <= 1'b0;
      sh_zoom <= 1'b0;
    end else if (tick_frame) begin
      sh_en   <= enable;
      sh_zoom <= zoom;
    end
  end

  // fetch engine; an unanswered request across a flush goes stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      stale     <= 1'b0;
      line_adr  <= '0;
      remaining <= '0;
      mem_adr   <= '0;
    end else begin
      busy <= mem_req && !mem_ack;
      if (kill) begin
        line_adr  <= nxt_line;
        remaining <= tick_arm ? words : '0;
        stale     <= mem_req && !mem_ack;
        if (!(mem_req && !mem_ack)) begin
          mem_adr <= nxt_line;
        end
      end else if (mem_req && mem_ack) begin
        if (stale) begin
          stale   <= 1'b0;
          mem_adr <= line_adr;
        end else begin
          mem_adr   <= mem_adr + 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end

  // line FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data;
    end
  end

  // line FIFO pointers; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (kill) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // registered video outputs, aligned one clk after the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      cur_word    <= '0;
      cur_valid   <= 1'b0;
    end else begin
      hsync       <= (hcnt >= HS_ON) && (hcnt < HS_OFF);
      vsync       <= (vcnt >= VS_ON) && (vcnt < VS_OFF);
      de          <= in_de;
      frame_start <= tick_frame;
      underflow   <= 1'b0;
      if (ce) begin
        rgb <= '0;
        if (in_de && sh_en) begin
          if (pop_due) begin
            if (pop) begin
              cur_word  <= head;
              cur_valid <= 1'b1;
              rgb       <= head[15:0];
            end else begin
              cur_valid <= 1'b0;
              underflow <= 1'b1;
            end
          end else if (cur_valid) begin
            rgb <= half ? cur_word[31:16] : cur_word[15:0];
          end else begin
            underflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: directed checks of timing, fetch, zoom,
// backpressure, coherency, reset and enable gating.
module tb_video_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b1;
  logic        enable = 1'b1;
  logic        zoom = 1'b0;
  logic [23:0] base_adr = 24'h100;
  logic        mem_req;
  logic [23:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [15:0] rgb;
  logic        frame_start;
  logic        underflow;

  logic        stall = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          pos = 0;
  int          uf_cnt = 0;
  int          req_cnt = 0;
  int          nz_cnt = 0;
  logic [23:0] rd_q[$];
  logic [15:0] pix_q[$];

  always #5 clk = ~clk;

  video_scanout #(
    .CORDW(11), .H_RES(8), .V_RES(4),
    .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(24), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .enable(enable), .zoom(zoom),
    .base_adr(base_adr),
    .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .hsync(hsync), .vsync(vsync), .de(de),
    .rgb(rgb), .frame_start(frame_start),
    .underflow(underflow)
  );

  function automatic logic [31:0] dat(input logic [23:0] a);
    return {4'h2, a[11:0], 4'h1, a[11:0]};
  endfunction

  function automatic logic [15:0] epix(
    input logic [23:0] b, input logic z,
    input int y, input int x);
    logic [23:0] a;
    logic hi;
    if (z) begin
      a  = b + 24'(2 * (y / 2) + x / 4);
      hi = ((x / 2) % 2) == 1;
    end else begin
      a  = b + 24'(4 * y + x / 2);
      hi = (x % 2) == 1;
    end
    return hi ? {4'h2, a[11:0]} : {4'h1, a[11:0]};
  endfunction

  // memory: ack one clk after a request is seen, unless stalled
  always @(negedge clk) begin
    mem_ack  = rst_n && mem_req && !mem_ack && !stall;
    mem_data = dat(mem_adr);
  end

  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack) rd_q.push_back(mem_adr);
  end

  always @(negedge clk) begin
    if (de) pix_q.push_back(rgb);
    if (underflow) uf_cnt++;
    if (mem_req) req_cnt++;
    if (rgb != 16'h0) nz_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input int k);
    tick(k - pos);
    pos = k;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 300);
    chk("fs_wait", {31'd0, frame_start}, 32'd1);
    pos = 0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_req"}, {31'd0, mem_req}, 0);
    chk({p, "_adr"}, {8'd0, mem_adr}, 0);
    chk({p, "_hs"}, {31'd0, hsync}, 0);
    chk({p, "_vs"}, {31'd0, vsync}, 0);
    chk({p, "_de"}, {31'd0, de}, 0);
    chk({p, "_rgb"}, {16'd0, rgb}, 0);
    chk({p, "_fs"}, {31'd0, frame_start}, 0);
    chk({p, "_uf"}, {31'd0, underflow}, 0);
  endtask

  task automatic chk_pix(input string p, input logic [23:0] b,
                         input logic z, input bit blank0);
    logic [15:0] v;
    logic [15:0] e;
    chk({p, "_npix"}, 32'(pix_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      v = (i < pix_q.size()) ? pix_q[i] : 16'hdead;
      e = (blank0 && i < 8) ? 16'h0 : epix(b, z, i / 8, i % 8);
      chk($sformatf("%s_pix%0d", p, i), {16'd0, v}, {16'd0, e});
    end
  endtask

  initial begin
    int n;
    int u0;
    int r0;
    int z0;
    logic [23:0] exp_z[8];
    logic [23:0] ra;

    #1 rst_n = 1'b0;
    tick(3);
    chk_zero("rst");
    rst_n = 1'b1;

    // frame 0: shadows pick up enable=1, zoom=0, base 0x100
    wait_fs(n);
    chk("pre_frame_reads", 32'(rd_q.size()), 0);
    rd_q.delete();
    pix_q.delete();
    u0 = uf_cnt;
    go(1);  chk("fs_pulse", {31'd0, frame_start}, 0);
    go(9);  chk("hs_9", {31'd0, hsync}, 0);
    go(10); chk("hs_10", {31'd0, hsync}, 1);
    go(11); chk("hs_11", {31'd0, hsync}, 1);
    go(12); chk("hs_12", {31'd0, hsync}, 0);
    go(13); chk("de_13", {31'd0, de}, 0);
    go(14); chk("de_14", {31'd0, de}, 1);
    go(22); chk("de_22", {31'd0, de}, 0);
    go(30);
    base_adr = 24'h200;
    zoom = 1'b1;
    go(70);
    chk("f0_nreads", 32'(rd_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ra = (i < rd_q.size()) ? rd_q[i] : 24'hffffff;
      chk($sformatf("f0_rd%0d", i), {8'd0, ra},
          32'h100 + 32'(i));
    end
    chk_pix("f0", 24'h100, 1'b0, 1'b0);
    chk("f0_uf", 32'(uf_cnt - u0), 0);
    go(83); chk("vs_83", {31'd0, vsync}, 0);
    go(84); chk("vs_84", {31'd0, vsync}, 1);
    go(97); chk("fs_97", {31'd0, frame_start}, 0);
    go(98); chk("fs_98", {31'd0, frame_start}, 1);

    // frame 1: zoom=1, base 0x200 (changed mid frame 0)
    pos = 0;
    rd_q.delete();
    pix_q.delete();
    go(40);
    zoom = 1'b0;
    go(70);
    exp_z = '{24'h200, 24'h201, 24'h200, 24'h201,
              24'h202, 24'h203, 24'h202, 24'h203};
    chk("f1_nreads", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      ra = (i < rd_q.size()) ? rd_q[i] : 24'hffffff;
      chk($sformatf("f1_rd%0d", i), {8'd0, ra}, {8'd0, exp_z[i]});
    end
    chk_pix("f1", 24'h200, 1'b1, 1'b0);
    stall = 1'b1;

    // frame 2: line 0 starved, line 1 onward intact
    wait_fs(n);
    pix_q.delete();
    u0 = uf_cnt;
    go(22);
    @(posedge clk);
    #1 stall = 1'b0;
    go(70);
    chk_pix("f2", 24'h200, 1'b0, 1'b1);
    chk("f2_uf", 32'(uf_cnt - u0), 32'd8);

    // reset while a request is pending
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 200);
    chk("req_seen", {31'd0, mem_req}, 1);
    rst_n = 1'b0;
    #1 chk("rst_req_now", {31'd0, mem_req}, 0);
    @(negedge clk);
    chk_zero("mid_rst");
    enable = 1'b0;
    rst_n = 1'b1;

    // enable=0 latched: a whole frame with no requests or pixels
    wait_fs(n);
    r0 = req_cnt;
    z0 = nz_cnt;
    u0 = uf_cnt;
    wait_fs(n);
    chk("frame_period", 32'(n), 32'd98);
    chk("dis_req", 32'(req_cnt - r0), 0);
    chk("dis_rgb", 32'(nz_cnt - z0), 0);
    chk("dis_uf", 32'(uf_cnt - u0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Parametrised framebuffer scan-out controller; successor to the fixed 640x480 SDRAM video block.
- Generates VGA-style timing and fetches 32-bit words (two RGB565 pixels) from memory over a req/ack handshake into a line FIFO.
- Adds frame-coherent base address, runtime 2x zoom, enable gating and underflow reporting.
- Sits between the SDRAM arbiter and the display PHY.

Parameters:
- CORDW, 11: counter width (bits).
- H_RES, 640: visible pixels per line. Must be a multiple of 4.
- V_RES, 480: visible lines. Must be even.
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal porches and sync, in pixels.
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical porches and sync, in lines.
- ADDR_W, 24: word address width.
- FIFO_DEPTH, 16: line FIFO depth in 32-bit words. Power of 2, at least 4.

Ports:
- clk, in, 1: single clock for timing and memory.
- rst_n, in, 1: asynchronous active-low reset.
- ce, in, 1: pixel-clock enable; timing advances only when high.
- enable, in, 1: scan-out enable.
- zoom, in, 1: 0 = native resolution; 1 = 2x2 pixel replication.
- base_adr, in, ADDR_W: framebuffer word address.
- mem_req, out, 1: read request.
- mem_adr, out, ADDR_W: read word address.
- mem_ack, in, 1: read data valid; completes the request.
- mem_data, in, 32: read data.
- hsync, out, 1: active-high horizontal sync.
- vsync, out, 1: active-high vertical sync.
- de, out, 1: data enable.
- rgb, out, 16: RGB565 pixel.
- frame_start, out, 1: one-clk pulse at start of frame.
- underflow, out, 1: one-clk pulse per starved pixel.

Behaviour:
- Reset: counters 0, FIFO empty, shadow registers 0. All outputs 0: mem_req, mem_adr, hsync, vsync, de, rgb, frame_start, underflow.
- Timing:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - On ce, hcnt increments and wraps to 0 at H_TOTAL-1; vcnt increments on each hcnt wrap and wraps to 0 at V_TOTAL-1.
  - hsync is high for H_RES+H_FP <= hcnt < H_RES+H_FP+H_SYNC. vsync uses the vertical equivalents.
  - de is high for hcnt<H_RES and vcnt<V_RES.
  - hsync, vsync, de and rgb are registered and mutually aligned, 1 clk after the counter state.
- Frame start: at the ce tick where hcnt=0 and vcnt=V_TOTAL-1:
  - Latch base_adr, zoom and enable into shadows.
  - Reset the line address to base_adr and flush the FIFO.
  - Pulse frame_start.
  - Inputs changed at any other time take effect only at the next frame start.
- Fetch:
  - Words per line W = H_RES/2 (zoom 0) or H_RES/4 (zoom 1).
  - A line fetch arms at hcnt=H_RES on vcnt=V_TOTAL-1 (for line 0) and on each vcnt<V_RES-1 (for the next line). Arming flushes the FIFO and loads remaining = W.
  - zoom 1: odd source lines re-fetch the same address as the preceding even line. The line address advances by W only after odd lines.
- Handshake:
  - Assert mem_req when remaining>0 and FIFO count < FIFO_DEPTH.
  - Hold mem_req and mem_adr stable until mem_ack.
  - On mem_ack, push mem_data, increment mem_adr, decrement remaining. mem_req may stay high for the next word (back-to-back).
  - At most one request is outstanding.
  - Shadow enable=0: no requests.
- Pixel output:
  - Pop a word at the first pixel of each word; low half first, then high half.
  - zoom 1: each half is shown for 2 pixels.
  - Outside de: rgb=0.
  - FIFO empty when a pop is due: rgb=0 for that word's pixels, underflow pulses once per starved pixel, and position still advances.
  - Shadow enable=0: rgb=0, no underflow.
- Simultaneous events:
  - Push and pop in the same clk leave count unchanged.
  - Arm flush has priority over a pop; a mem_ack arriving in the arm clk is discarded if it belongs to the previous line.
- Mid-operation reset (rst_n low) returns everything to reset values immediately, including dropping mem_req.

Test Plan:
- Timing, H_RES=8, V_RES=4, porches 2/2/2 and 1/1/1, ce=1 → hsync high for hcnt 10-11, line period 14 clk, vsync high on vcnt 5, frame 98 clk, frame_start once per 98 clk.
- Fetch, zoom=0, base_adr=0x100, mem_ack 1 clk after each req → 4 reads/line at 0x100-0x103, then 0x104-0x107. Word 0x22221111 shows rgb 0x1111 then 0x2222.
- Zoom, zoom=1 → 2 reads/line; lines 0 and 1 both read 0x100-0x101; each pixel repeated twice horizontally.
- Backpressure, mem_ack held low 40 clk on line 0 → rgb=0 and underflow pulses on starved pixels; line 1 fetched and displayed correctly.
- Coherency, base_adr changed to 0x200 mid-frame → current frame still reads 0x10x; next frame starts at 0x200.
- Reset and enable: rst_n low while mem_req=1 → all outputs 0 next clk. enable=0 at frame start → no mem_req for the whole frame, rgb=0.
